// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised, optionally debounced input bus with
// per-bit edge capture (RW1C), interrupt mask and level interrupt.
module pio_in_edge_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_MODE       = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] stable_p1;
    logic [WIDTH-1:0] prev_p2;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] capture_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic             unused_wdata;

    // Stage p0: metastability synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
        end else begin
            sync_p0[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
        end
    end

    assign sync_s = sync_p0[SYNC_STAGES-1];

    // Stage p1: debounced stable value
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stable_p1 <= '0;
                else          stable_p1 <= sync_s;
            end
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0] cnt [WIDTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_p1 <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync_s[i] == stable_p1[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            stable_p1[i] <= sync_s[i];
                            cnt[i]       <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    // Stage p2: previous stable value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_p2 <= '0;
        else          prev_p2 <= stable_p1;
    end

    assign rise     = stable_p1 & ~prev_p2;
    assign fall     = ~stable_p1 & prev_p2;
    assign edge_set = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);

    assign wr_en = chipselect & ~write_n;
    assign w1c   = (wr_en && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

    // Bits above WIDTH are deliberately ignored on writes
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= '0;
            capture_q <= '0;
        end else begin
            if (wr_en && address == ADDR_MASK) mask_q <= writedata[WIDTH-1:0];
            // A new edge overrides a clear landing on the same bit
            capture_q <= (capture_q & ~w1c) | edge_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                ADDR_DATA:    readdata <= 32'(stable_p1);
                ADDR_MASK:    readdata <= 32'(mask_q);
                ADDR_CAPTURE: readdata <= 32'(capture_q);
                default:      readdata <= 32'd0;
            endcase
        end
    end

    assign irq = |(capture_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: three instances cover the plain rising
// configuration, debounced any-edge, and falling-edge capture.
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'hFF;

    logic [31:0] rd_dut, rd_dbn, rd_fall;
    logic        irq_dut, irq_dbn, irq_fall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_dut), .irq(irq_dut)
    );

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_dbn (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_dbn), .irq(irq_dbn)
    );

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic settle_clear();
        step(12);
        bus_wr(2'd3, 32'hFFFF_FFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inputs held high
        step(5);
        chk("rst_rdata", rd_dut, 32'h0);
        chk("rst_irq", {31'd0, irq_dut}, 32'h0);
        reset_n = 1'b1;
        address = 2'd0;
        step(3);
        chk("data_early", rd_dut, 32'h0);
        step(1);
        chk("data_ff", rd_dut, 32'h0000_00FF);

        in_port = 8'h00;
        settle_clear();
        bus_rd(2'd3);
        chk("cap_clean_dut", rd_dut, 32'h0);
        chk("cap_clean_dbn", rd_dbn, 32'h0);
        chk("cap_clean_fall", rd_fall, 32'h0);

        // Rising capture on bit 0 with no debounce
        bus_wr(2'd2, 32'hFFFF_FF01);
        in_port = 8'h01;
        step(3);
        chk("irq_before", {31'd0, irq_dut}, 32'h0);
        step(1);
        chk("irq_rise", {31'd0, irq_dut}, 32'h1);
        bus_rd(2'd3);
        chk("cap_rise", rd_dut, 32'h0000_0001);
        bus_rd(2'd2);
        chk("mask_rb", rd_dut, 32'h0000_0001);
        bus_rd(2'd1);
        chk("rsvd", rd_dut, 32'h0);
        bus_wr(2'd3, 32'h0000_0001);
        chk("irq_clr", {31'd0, irq_dut}, 32'h0);
        bus_rd(2'd3);
        chk("cap_clr", rd_dut, 32'h0);

        // Debounce: short glitch rejected, long pulse accepted
        in_port = 8'h00;
        settle_clear();
        address = 2'd0;
        in_port = 8'h04;
        step(3);
        in_port = 8'h00;
        step(10);
        chk("glitch_data", rd_dbn, 32'h0);
        bus_rd(2'd3);
        chk("glitch_cap", rd_dbn, 32'h0);
        address = 2'd0;
        in_port = 8'h04;
        step(6);
        chk("dbn_early", rd_dbn, 32'h0);
        step(1);
        chk("dbn_data", rd_dbn, 32'h0000_0004);
        step(3);
        in_port = 8'h00;
        bus_rd(2'd3);
        chk("dbn_cap", rd_dbn, 32'h0000_0004);

        // Set wins over a same-edge W1C
        settle_clear();
        in_port = 8'h02;
        step(3);
        bus_wr(2'd3, 32'h0000_0002);
        bus_rd(2'd3);
        chk("collide", rd_dut, 32'h0000_0002);
        bus_wr(2'd3, 32'h0000_0002);
        bus_rd(2'd3);
        chk("collide_clr", rd_dut, 32'h0);

        // Any-edge vs falling-edge on bit 7
        in_port = 8'h00;
        settle_clear();
        in_port = 8'h80;
        step(12);
        bus_rd(2'd3);
        chk("any_rise", rd_dbn, 32'h0000_0080);
        chk("fall_on_rise", rd_fall, 32'h0);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        in_port = 8'h00;
        step(12);
        bus_rd(2'd3);
        chk("any_fall", rd_dbn, 32'h0000_0080);
        chk("fall_on_fall", rd_fall, 32'h0000_0080);
        chk("rise_on_fall", rd_dut, 32'h0);
        bus_wr(2'd3, 32'hFFFF_FFFF);

        // Mask gating and reset with irq high
        bus_wr(2'd2, 32'h0);
        in_port = 8'h10;
        step(6);
        chk("masked_irq", {31'd0, irq_dut}, 32'h0);
        bus_rd(2'd3);
        chk("masked_cap", rd_dut, 32'h0000_0010);
        bus_wr(2'd2, 32'h0000_0010);
        chk("unmask_irq", {31'd0, irq_dut}, 32'h1);
        bus_wr(2'd2, 32'h0);
        chk("remask_irq", {31'd0, irq_dut}, 32'h0);
        bus_rd(2'd3);
        chk("remask_cap", rd_dut, 32'h0000_0010);
        bus_wr(2'd2, 32'h0000_0010);
        chk("irq_pre_rst", {31'd0, irq_dbn}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_irq_dut", {31'd0, irq_dut}, 32'h0);
        chk("rst_irq_dbn", {31'd0, irq_dbn}, 32'h0);
        chk("rst_rd_async", rd_dut, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
